// File: rtl/tx232_sched_if.sv
// Channel-side bundle between the requesting channels and the RS-232 frame scheduler.
// The scheduler takes the slave view; the channels/bench drive the master view.
interface tx232_sched_if #(
    parameter int N = 4
);
    logic             txck;
    logic [N-1:0]     req;
    logic [16*N-1:0]  din;
    logic [15:0]      bcd;
    logic             start;
    logic [N-1:0]     gnt;
    logic [N-1:0]     ack;
    logic             busy;

    modport master (
        output txck, req, din,
        input  bcd, start, gnt, ack, busy
    );

    modport slave (
        input  txck, req, din,
        output bcd, start, gnt, ack, busy
    );
endinterface

// File: rtl/tx232_sched.sv
// Round-robin scheduler sharing one RS-232 packetizer among N channels: it latches the
// granted word onto bcd, holds start for FRAME_TCK baud edges, then keeps a GAP_TCK guard gap.
module tx232_sched #(
    parameter int N         = 4,
    parameter int FRAME_TCK = 24,
    parameter int GAP_TCK   = 2
) (
    input logic          clk,
    input logic          rst,
    tx232_sched_if.slave bus
);
    localparam int         PW         = (N > 1) ? $clog2(N) : 1;
    localparam logic [7:0] FRAME_LAST = 8'(FRAME_TCK - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_TCK - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [15:0]     bcd_q, bcd_d;
    logic            start_q, start_d;
    logic            busy_q, busy_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [N-1:0]    ack_q, ack_d;
    logic [1:0]      txck_sync_q;
    logic            txck_r;

    logic [15:0]     din_w [N];
    logic            sel_found;
    logic [PW-1:0]   sel_idx;
    logic [15:0]     sel_word;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_word
            assign din_w[gi] = bus.din[16*gi +: 16];
        end
    endgenerate

    // Only the rising edge of the baud clock advances the frame/gap counters.
    assign txck_r = txck_sync_q[0] & ~txck_sync_q[1];

    // First requester strictly after the last served channel, wrapping modulo N.
    always_comb begin
        int            idx;
        logic [PW-1:0] cand;
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 1; k <= N; k++) begin
            idx  = (int'(ptr_q) + k) % N;
            cand = PW'(idx);
            if (!sel_found && bus.req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign sel_word = din_w[sel_idx];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        start_d = start_q;
        busy_d  = busy_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    gnt_d          = '0;
                    gnt_d[sel_idx] = 1'b1;
                    bcd_d          = sel_word;
                    start_d        = 1'b1;
                    busy_d         = 1'b1;
                    ptr_d          = sel_idx;
                    cnt_d          = '0;
                    state_d        = S_SEND;
                end
            end
            S_SEND: begin
                if (txck_r) begin
                    if (cnt_q == FRAME_LAST) begin
                        start_d = 1'b0;
                        ack_d   = gnt_q;
                        cnt_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_GAP: begin
                if (txck_r) begin
                    if (cnt_q == GAP_LAST) begin
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= PW'(N - 1);
            cnt_q       <= '0;
            bcd_q       <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            gnt_q       <= '0;
            ack_q       <= '0;
            txck_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            txck_sync_q <= {txck_sync_q[0], bus.txck};
        end
    end

    assign bus.bcd   = bcd_q;
    assign bus.start = start_q;
    assign bus.busy  = busy_q;
    assign bus.gnt   = gnt_q;
    assign bus.ack   = ack_q;
endmodule

// File: tb/tb_tx232_sched.sv
// Bench for tx232_sched: directed scenarios plus randomized traffic, compared every clock
// against a frame-level reference model that counts remaining baud edges per frame/gap.
module tb_tx232_sched;
    localparam int N         = 4;
    localparam int FRAME_TCK = 24;
    localparam int GAP_TCK   = 2;

    logic clk = 1'b0;
    logic rst;

    tx232_sched_if #(.N(N)) bus ();

    tx232_sched #(
        .N         (N),
        .FRAME_TCK (FRAME_TCK),
        .GAP_TCK   (GAP_TCK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec     = 0;
    int n_err     = 0;
    int txck_half = 2;
    bit run_chk   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: frame-level view (idle / sending / gap) with edges remaining.
    int          m_phase;   // 0 idle, 1 sending, 2 gap
    int          m_left;
    int          m_ptr;
    logic        m_s0, m_s1;
    logic [15:0] e_bcd;
    logic        e_start, e_busy;
    logic [N-1:0] e_gnt, e_ack;

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        logic [N-1:0] sh;
        for (int k = 1; k <= N; k++) begin
            int c;
            c  = (p + k) % N;
            sh = r >> c;
            if (sh[0]) return c;
        end
        return -1;
    endfunction

    initial begin
        logic            rise;
        int              sel;
        logic [16*N-1:0] tmp;
        m_phase = 0; m_left = 0; m_ptr = N - 1;
        m_s0 = 1'b0; m_s1 = 1'b0;
        e_bcd = '0; e_start = 1'b0; e_busy = 1'b0; e_gnt = '0; e_ack = '0;
        forever begin
            @(posedge clk);
            rise = m_s0 & ~m_s1;
            if (rst) begin
                m_phase = 0; m_left = 0; m_ptr = N - 1;
                m_s0 = 1'b0; m_s1 = 1'b0;
                e_bcd = '0; e_start = 1'b0; e_busy = 1'b0; e_gnt = '0; e_ack = '0;
                run_chk = 1'b1;
            end else begin
                m_s1  = m_s0;
                m_s0  = bus.txck;
                e_ack = '0;
                if (m_phase == 0) begin
                    sel = rr_pick(bus.req, m_ptr);
                    if (sel >= 0) begin
                        tmp     = bus.din >> (16 * sel);
                        e_bcd   = tmp[15:0];
                        e_gnt   = N'(1) << sel;
                        e_start = 1'b1;
                        e_busy  = 1'b1;
                        m_ptr   = sel;
                        m_left  = FRAME_TCK;
                        m_phase = 1;
                    end
                end else if (rise) begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_phase == 1) begin
                            e_start = 1'b0;
                            e_ack   = e_gnt;
                            m_left  = GAP_TCK;
                            m_phase = 2;
                        end else begin
                            e_gnt   = '0;
                            e_busy  = 1'b0;
                            m_phase = 0;
                        end
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (run_chk) begin
            check_eq("bcd",   32'(bus.bcd),   32'(e_bcd));
            check_eq("start", 32'(bus.start), 32'(e_start));
            check_eq("busy",  32'(bus.busy),  32'(e_busy));
            check_eq("gnt",   32'(bus.gnt),   32'(e_gnt));
            check_eq("ack",   32'(bus.ack),   32'(e_ack));
            check_eq("gnt_onehot", 32'($countones(bus.gnt) <= 1), 32'(1));
            check_eq("ack_onehot", 32'($countones(bus.ack) <= 1), 32'(1));
            if (|bus.ack)
                $display("frame done: ack=%b bcd=%h t=%0t", bus.ack, bus.bcd, $time);
        end
    end

    initial begin
        bus.txck = 1'b0;
        forever begin
            repeat (txck_half) @(negedge clk);
            bus.txck = ~bus.txck;
        end
    end

    task automatic set_word(input int ch, input logic [15:0] w);
        bus.din[16*ch +: 16] = w;
    endtask

    task automatic wait_ack(input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (|bus.ack) break;
        end
        check_eq("ack_seen", 32'(|bus.ack), 32'(1));
    endtask

    task automatic wait_gnt(input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (|bus.gnt) break;
        end
        check_eq("gnt_seen", 32'(|bus.gnt), 32'(1));
    endtask

    task automatic wait_idle(input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        check_eq("idle_seen", 32'(bus.busy), 32'(0));
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        bus.req = '0;
        bus.din = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single request on ch2
        set_word(2, 16'h1234);
        bus.req = 4'b0100;
        @(negedge clk);
        check_eq("t1_gnt", 32'(bus.gnt), 32'h4);
        check_eq("t1_bcd", 32'(bus.bcd), 32'h1234);
        wait_ack(2000);
        check_eq("t1_ack", 32'(bus.ack), 32'h4);
        bus.req = '0;
        wait_idle(200);

        // All four requesting: ch0, ch1, ch2, ch3, ch0
        pulse_rst();
        for (int c = 0; c < N; c++) set_word(c, 16'(c + 1));
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ack(2000);
            check_eq("t2_ack", 32'(bus.ack), 32'(1 << (i % 4)));
            check_eq("t2_bcd", 32'(bus.bcd), 32'((i % 4) + 1));
        end
        bus.req = '0;
        wait_idle(200);

        // Served channel drops req and changes data mid-frame
        set_word(1, 16'hABCD);
        bus.req = 4'b0010;
        wait_gnt(200);
        repeat (5) @(posedge bus.txck);
        @(negedge clk);
        bus.req = '0;
        set_word(1, 16'hFFFF);
        wait_ack(2000);
        check_eq("t3_ack", 32'(bus.ack), 32'h2);
        check_eq("t3_bcd", 32'(bus.bcd), 32'hABCD);
        wait_idle(200);

        // Lone repeating requester
        bus.req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            wait_ack(2000);
            check_eq("t4_ack", 32'(bus.ack), 32'h1);
            wait_idle(200);
        end
        bus.req = '0;
        wait_idle(200);

        // Reset in the middle of a frame
        pulse_rst();
        bus.req = 4'b1111;
        wait_gnt(200);
        repeat (10) @(posedge bus.txck);
        @(negedge clk);
        rst     = 1'b1;
        bus.req = 4'b1000;
        @(negedge clk);
        check_eq("t5_start", 32'(bus.start), 32'(0));
        check_eq("t5_gnt",   32'(bus.gnt),   32'(0));
        rst = 1'b0;
        @(negedge clk);
        check_eq("t5_regnt", 32'(bus.gnt), 32'h8);
        bus.req = '0;
        wait_idle(2000);

        // Late arrivals while ch2 is served: ch3 then ch0
        pulse_rst();
        bus.req = 4'b0100;
        wait_gnt(200);
        check_eq("t6_first", 32'(bus.gnt), 32'h4);
        bus.req = 4'b1101;
        wait_ack(2000);
        bus.req = 4'b1001;
        wait_idle(200);
        wait_gnt(200);
        check_eq("t6_second", 32'(bus.gnt), 32'h8);
        wait_ack(2000);
        bus.req = 4'b0001;
        wait_idle(200);
        wait_gnt(200);
        check_eq("t6_third", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        wait_idle(2000);

        // Randomized traffic
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 699) == 0);
            if ($urandom_range(0, 19) == 0) bus.req = N'($urandom);
            if ($urandom_range(0, 9) == 0)
                set_word(int'($urandom_range(0, N - 1)), 16'($urandom));
            if ($urandom_range(0, 299) == 0) txck_half = int'($urandom_range(1, 3));
        end
        @(negedge clk);
        rst     = 1'b0;
        bus.req = '0;
        wait_idle(2000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
